// File: rtl/arcfour_pkg.sv
// Shared definitions for the arcfour key-search controller: key geometry,
// default message length, controller states and the plaintext byte rule.
package arcfour_pkg;

  localparam int KEY_W       = 22;
  localparam int KEY_BYTES   = 3;
  localparam int MSG_LEN_DEF = 32;

  typedef enum logic [3:0] {
    KS_IDLE,
    KS_LAUNCH,
    KS_WAIT_CORE,
    KS_RD_ADDR,
    KS_RD_WAIT,
    KS_CHECK,
    KS_NEXT,
    KS_DONE,
    KS_FAIL
  } ks_state_t;

  // Plaintext is accepted only as lowercase ASCII letters or space.
  function automatic logic is_plain(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
  endfunction

endpackage

// File: rtl/key_search.sv
// Steps a 22-bit key through [KEY_START, KEY_END], launches one arcfour run per
// candidate and scans the decrypted RAM until a fully plain message is found.
module key_search
  import arcfour_pkg::*;
#(
  parameter int                MSG_LEN   = MSG_LEN_DEF,
  parameter logic [KEY_W-1:0]  KEY_START = 22'h000000,
  parameter logic [KEY_W-1:0]  KEY_END   = 22'h3FFFFF,
  localparam int               ADDR_W    = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  output logic [KEY_BYTES-1:0][7:0]  key,
  output logic                       core_start,
  input  logic                       core_finished,
  output logic [ADDR_W-1:0]          msg_addr,
  input  logic [7:0]                 msg_q,
  output logic                       busy,
  output logic                       found,
  output logic                       exhausted,
  output logic [23:0]                found_key
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN - 1);

  ks_state_t         state;
  logic [KEY_W-1:0]  cand;
  logic [ADDR_W-1:0] idx;
  logic              wait_first;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= KS_IDLE;
      cand       <= '0;
      idx        <= '0;
      wait_first <= 1'b0;
      busy       <= 1'b0;
      found      <= 1'b0;
      exhausted  <= 1'b0;
      found_key  <= '0;
    end else begin
      case (state)
        KS_IDLE, KS_DONE, KS_FAIL: begin
          if (start) begin
            cand      <= KEY_START;
            idx       <= '0;
            found     <= 1'b0;
            exhausted <= 1'b0;
            found_key <= '0;
            busy      <= 1'b1;
            state     <= KS_LAUNCH;
          end
        end
        KS_LAUNCH: begin
          wait_first <= 1'b1;
          state      <= KS_WAIT_CORE;
        end
        KS_WAIT_CORE: begin
          // The core may still show finished from the previous run for one cycle.
          wait_first <= 1'b0;
          if (!wait_first && core_finished) state <= KS_RD_ADDR;
        end
        KS_RD_ADDR: state <= KS_RD_WAIT;
        KS_RD_WAIT: state <= KS_CHECK;
        KS_CHECK: begin
          if (!is_plain(msg_q)) begin
            state <= KS_NEXT;
          end else if (idx == LAST_IDX) begin
            found_key <= {2'b00, cand};
            found     <= 1'b1;
            busy      <= 1'b0;
            state     <= KS_DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= KS_RD_ADDR;
          end
        end
        KS_NEXT: begin
          if (cand == KEY_END) begin
            exhausted <= 1'b1;
            busy      <= 1'b0;
            state     <= KS_FAIL;
          end else begin
            cand  <= cand + 1'b1;
            idx   <= '0;
            state <= KS_LAUNCH;
          end
        end
        default: state <= KS_IDLE;
      endcase
    end
  end

  assign core_start = (state == KS_LAUNCH);
  assign key        = {{(KEY_BYTES*8-KEY_W){1'b0}}, cand};
  assign msg_addr   = idx;

endmodule

// File: tb/tb_key_search.sv
// Bench for key_search: two instances (full range and top-of-range) driven by an
// arcfour/RAM behavioural model, with a queue-based scoreboard and monitor.
module tb_key_search;

  localparam int MLEN = 32;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [1:0] start = 2'b00;

  logic [23:0] key_v  [2];
  logic        cs_v   [2];
  logic [4:0]  addr_v [2];
  logic        busy_v [2];
  logic        found_v[2];
  logic        exh_v  [2];
  logic [23:0] fkey_v [2];
  bit          fin    [2];
  logic [7:0]  q_v    [2];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_search #(.MSG_LEN(32), .KEY_START(22'h000000), .KEY_END(22'h3FFFFF)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .key(key_v[0]),
    .core_start(cs_v[0]), .core_finished(fin[0]), .msg_addr(addr_v[0]),
    .msg_q(q_v[0]), .busy(busy_v[0]), .found(found_v[0]),
    .exhausted(exh_v[0]), .found_key(fkey_v[0]));

  key_search #(.MSG_LEN(32), .KEY_START(22'h3FFFFD), .KEY_END(22'h3FFFFF)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .key(key_v[1]),
    .core_start(cs_v[1]), .core_finished(fin[1]), .msg_addr(addr_v[1]),
    .msg_q(q_v[1]), .busy(busy_v[1]), .found(found_v[1]),
    .exhausted(exh_v[1]), .found_key(fkey_v[1]));

  // World definition: which key decrypts to which plaintext
  logic [21:0] target [2];
  int          kind_a [2];
  logic [31:0] seed   [2];

  function automatic logic [21:0] ks_of(input int lane);
    return (lane == 0) ? 22'h000000 : 22'h3FFFFD;
  endfunction

  function automatic logic [7:0] pang_byte(input int i);
    string s;
    s = "the quick brown fox jumps over a";
    return s[i];
  endfunction

  function automatic logic [7:0] blist(input int i);
    case (i)
      0: return 8'h60;
      1: return 8'h7B;
      2: return 8'h1F;
      3: return 8'h41;
      4: return 8'h00;
      5: return 8'h80;
      6: return 8'h2E;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [31:0] hsh(input logic [21:0] k, input logic [31:0] s);
    logic [31:0] x;
    x = ({10'd0, k} ^ s) * 32'h9E3779B1;
    x = x ^ (x >> 15);
    x = x * 32'h85EBCA6B;
    return x ^ (x >> 13);
  endfunction

  function automatic logic [7:0] msg_byte(input int lane, input logic [21:0] k, input int idx);
    logic [31:0] h;
    int          bp;
    logic [7:0]  bad;
    if (k == target[lane]) begin
      if (kind_a[lane] == 0) return pang_byte(idx);
      case ((idx + int'(k[3:0])) % 3)
        0: return 8'h61;
        1: return 8'h7A;
        default: return 8'h20;
      endcase
    end
    h = hsh(k, seed[lane]);
    if (k < 22'd4) begin
      bp  = (k == 22'd3) ? 0 : int'(k) * 7;
      bad = blist(int'(k));
    end else begin
      bp  = int'(h % 32'd4);
      bad = blist(int'((h >> 3) % 32'd8));
    end
    if (idx == bp) return bad;
    if (((h >> (idx % 16)) & 32'h7) == 32'h0) return 8'h20;
    return 8'h61 + 8'((h >> (idx % 13)) % 32'd26);
  endfunction

  // Reference: the plaintext rule and the first offending byte position
  function automatic bit ref_plain(input logic [7:0] b);
    return (b inside {[8'h61:8'h7A]}) || (b == 8'h20);
  endfunction

  function automatic int first_bad(input int lane, input logic [21:0] k);
    for (int i = 0; i < MLEN; i++)
      if (!ref_plain(msg_byte(lane, k, i))) return i;
    return MLEN;
  endfunction

  // Scoreboard storage: per-launch expectations and per-search results
  logic [21:0] lq_key  [2][1024];
  int          lq_reads[2][1024];
  int          lq_wr[2];
  int          lq_rd[2];
  bit          res_found[2][8];
  logic [21:0] res_key  [2][8];
  int          res_n    [2][8];
  int          res_wr[2];
  int          res_rd[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // arcfour core and decrypted-message RAM model
  int          cnt    [2];
  logic [21:0] cur_key[2];
  logic [21:0] ram_key[2];

  initial begin
    for (int g = 0; g < 2; g++) begin
      cnt[g] = 0; cur_key[g] = '0; ram_key[g] = '0;
      target[g] = '0; kind_a[g] = 1; seed[g] = '0;
    end
  end

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (cs_v[g]) begin
        cnt[g]     <= int'($urandom_range(2, 6));
        cur_key[g] <= key_v[g][21:0];
      end else if (cnt[g] > 1) begin
        fin[g] <= 1'b0;
        cnt[g] <= cnt[g] - 1;
      end else if (cnt[g] == 1) begin
        fin[g]     <= 1'b1;
        cnt[g]     <= 0;
        ram_key[g] <= cur_key[g];
      end
      q_v[g] <= msg_byte(g, ram_key[g], int'(addr_v[g]));
    end
  end

  // Monitor
  bit prev_cs  [2];
  bit prev_busy[2];
  bit prev_fin [2];
  bit have_prev[2];
  int t_rise   [2];
  int cur_reads[2];
  int n_launch [2];

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!reset_n) begin
        have_prev[g] = 1'b0;
        n_launch[g]  = 0;
      end else begin
        if (fin[g] && !prev_fin[g]) t_rise[g] = cyc;
        if (cs_v[g]) begin
          check("core_start_single", prev_cs[g], 1'b0);
          check("launch_expected", lq_rd[g] != lq_wr[g], 1'b1);
          if (lq_rd[g] != lq_wr[g]) begin
            check("launch_key", key_v[g], {2'b00, lq_key[g][lq_rd[g] % 1024]});
            check("launch_busy", busy_v[g], 1'b1);
            if (have_prev[g])
              check("cand_cycles", cyc - t_rise[g], 3 * cur_reads[g] + 2);
            cur_reads[g] = lq_reads[g][lq_rd[g] % 1024];
            lq_rd[g]++;
            have_prev[g] = 1'b1;
            n_launch[g]++;
          end
        end
        if (prev_busy[g] && !busy_v[g]) begin
          check("result_expected", res_rd[g] != res_wr[g], 1'b1);
          if (res_rd[g] != res_wr[g]) begin
            check("found", found_v[g], res_found[g][res_rd[g] % 8]);
            check("exhausted", exh_v[g], !res_found[g][res_rd[g] % 8]);
            check("found_key", fkey_v[g],
                  res_found[g][res_rd[g] % 8] ? {2'b00, res_key[g][res_rd[g] % 8]} : 24'h0);
            check("launch_count", n_launch[g], res_n[g][res_rd[g] % 8]);
            check("launch_q_empty", lq_rd[g] == lq_wr[g], 1'b1);
            check("found_not_exh", found_v[g] & exh_v[g], 1'b0);
            check("end_cycles", cyc - t_rise[g],
                  3 * cur_reads[g] + (res_found[g][res_rd[g] % 8] ? 1 : 2));
            res_rd[g]++;
          end
          have_prev[g] = 1'b0;
          n_launch[g]  = 0;
        end
      end
      prev_cs[g]   = cs_v[g];
      prev_busy[g] = busy_v[g];
      prev_fin[g]  = fin[g];
    end
  end

  // Stimulus
  task automatic begin_search(input int lane, input logic [21:0] tgt, input int knd);
    logic [21:0] k;
    int          fb;
    int          nl;
    bit          done;
    target[lane] = tgt;
    kind_a[lane] = knd;
    seed[lane]   = $urandom;
    k = ks_of(lane);
    nl = 0;
    done = 1'b0;
    while (!done) begin
      fb = first_bad(lane, k);
      lq_key[lane][lq_wr[lane] % 1024]   = k;
      lq_reads[lane][lq_wr[lane] % 1024] = (fb == MLEN) ? MLEN : fb + 1;
      lq_wr[lane]++;
      nl++;
      if (fb == MLEN) begin
        res_found[lane][res_wr[lane] % 8] = 1'b1;
        res_key[lane][res_wr[lane] % 8]   = k;
        done = 1'b1;
      end else if (k == 22'h3FFFFF) begin
        res_found[lane][res_wr[lane] % 8] = 1'b0;
        res_key[lane][res_wr[lane] % 8]   = '0;
        done = 1'b1;
      end else begin
        k++;
      end
    end
    res_n[lane][res_wr[lane] % 8] = nl;
    res_wr[lane]++;
    @(posedge clk);
    #1 check("busy_before_start", busy_v[lane], 1'b0);
    start[lane] = 1'b1;
    @(posedge clk);
    #1 start[lane] = 1'b0;
    check("busy_after_start", busy_v[lane], 1'b1);
    check("found_cleared", found_v[lane], 1'b0);
    check("exh_cleared", exh_v[lane], 1'b0);
    check("found_key_cleared", fkey_v[lane], 24'h0);
  endtask

  task automatic finish_search(input int lane, input int poke);
    int n;
    n = 0;
    while (res_rd[lane] != res_wr[lane] && n < 40000) begin
      @(posedge clk);
      n++;
      if (n == poke) begin
        #1 start[lane] = 1'b1;
        @(posedge clk);
        n++;
        #1 start[lane] = 1'b0;
        check("busy_hold_on_start", busy_v[lane], 1'b1);
      end
    end
    check("search_completes", res_rd[lane] == res_wr[lane], 1'b1);
    if (res_rd[lane] != res_wr[lane]) begin
      res_rd[lane] = res_wr[lane];
      lq_rd[lane]  = lq_wr[lane];
    end
  endtask

  task automatic check_reset_vals(input int g);
    check("rst_key", key_v[g], 24'h0);
    check("rst_core_start", cs_v[g], 1'b0);
    check("rst_msg_addr", addr_v[g], 5'h0);
    check("rst_busy", busy_v[g], 1'b0);
    check("rst_found", found_v[g], 1'b0);
    check("rst_exhausted", exh_v[g], 1'b0);
    check("rst_found_key", fkey_v[g], 24'h0);
  endtask

  initial begin
    logic [21:0] tgt;
    int          seen;
    int          n;

    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_vals(0);
    check_reset_vals(1);
    #3 reset_n = 1'b1;
    repeat (3) @(posedge clk);

    // Top of range, nothing passes: three launches then exhausted, no wrap
    begin_search(1, 22'h000000, 1);
    finish_search(1, 0);
    repeat (5) @(posedge clk);
    #1 check("fail_hold_key", key_v[1], 24'h3FFFFF);
    check("fail_hold_exh", exh_v[1], 1'b1);
    check("fail_hold_found", found_v[1], 1'b0);
    check("fail_hold_busy", busy_v[1], 1'b0);

    // Boundary bytes: only 61/7A/20 passes; 60/7B/1F/41 garbage precede it
    tgt = 22'($urandom_range(4, 9));
    begin_search(0, tgt, 1);
    finish_search(0, 20);
    repeat (4) @(posedge clk);
    #1 check("done_hold_found", found_v[0], 1'b1);
    check("done_hold_key", fkey_v[0], {2'b00, tgt});

    // New search straight out of DONE
    tgt = 22'($urandom_range(10, 40));
    begin_search(0, tgt, 1);
    finish_search(0, 0);

    // Reset while waiting on the core
    begin_search(0, 22'h000249, 0);
    seen = 0;
    n = 0;
    while (seen < 3 && n < 5000) begin
      @(negedge clk);
      if (cs_v[0]) seen++;
      n++;
    end
    check("launches_before_reset", seen, 3);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_vals(0);
    check("rst_lane1_exh", exh_v[1], 1'b0);
    lq_rd[0]  = lq_wr[0];
    res_rd[0] = res_wr[0];
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (6) @(posedge clk);

    // Pangram at 0x249 from KEY_START=0
    begin_search(0, 22'h000249, 0);
    finish_search(0, 0);
    repeat (3) @(posedge clk);
    #1 check("pangram_found", found_v[0], 1'b1);
    check("pangram_key", fkey_v[0], 24'h000249);
    check("pangram_busy", busy_v[0], 1'b0);
    check("pangram_exh", exh_v[0], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
